// File: rtl/dropout_pkg.sv
// Shared dropout definitions: LFSR constants, step function and keep-mask
// derivation. Forward gate and backward replay both import this so their
// mask sequences stay bit-identical.
package dropout_pkg;

    localparam int          LFSR_W        = 16;
    localparam int          NUM_NEURONS   = 8;
    // x^16+x^14+x^13+x^11+1 -> feedback from bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] ZERO_SEED_DEF = 16'hACE1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [NUM_NEURONS-1:0] grad;
        logic [NUM_NEURONS-1:0] mask;
    } beat_t;

    // One Fibonacci step: shift left, feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    // Neuron i kept when its 2-bit random field is at or above the drop level
    function automatic logic [NUM_NEURONS-1:0] keep_mask(input logic [LFSR_W-1:0] l,
                                                         input logic [1:0]        lvl);
        logic [NUM_NEURONS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_NEURONS; i++)
            m[i] = (l[2*i +: 2] >= lvl);
        return m;
    endfunction

endpackage

// File: rtl/dropout_lfsr16.sv
// 16-bit LFSR with seed load and single-step advance. A zero seed is
// replaced by ZERO_SEED so the register never locks up at 0.
module dropout_lfsr16
    import dropout_pkg::*;
#(
    parameter logic [LFSR_W-1:0] ZERO_SEED = ZERO_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic [LFSR_W-1:0] lfsr_q
);

    // Load has priority over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= ZERO_SEED;
        else if (load)
            lfsr_q <= (seed == '0) ? ZERO_SEED : seed;
        else if (adv)
            lfsr_q <= lfsr_next(lfsr_q);
    end

endmodule

// File: rtl/dropout_mask_replay.sv
// Backward-pass dropout: replays the forward keep-mask sequence from the
// shared seed and gates each gradient beat with the mask of the matching
// forward beat. Single output register, valid/ready on both sides.
module dropout_mask_replay
    import dropout_pkg::*;
#(
    parameter int                DROP_LVL  = 2,
    parameter logic [LFSR_W-1:0] ZERO_SEED = ZERO_SEED_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   seed_load,
    input  logic [LFSR_W-1:0]      seed,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_NEURONS-1:0] grad_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] grad_out,
    output logic [NUM_NEURONS-1:0] mask_out,
    output logic [15:0]            beat_cnt
);

    localparam logic [1:0] LVL = DROP_LVL[1:0];

    state_t                 state, state_nxt;
    logic [LFSR_W-1:0]      lfsr;
    logic [NUM_NEURONS-1:0] mask;
    logic                   accept;
    beat_t                  out_q;

    // LFSR only steps on an accepted beat, so beat n sees n advances
    dropout_lfsr16 #(.ZERO_SEED(ZERO_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (seed_load),
        .seed   (seed),
        .adv    (accept),
        .lfsr_q (lfsr)
    );

    assign mask   = keep_mask(lfsr, LVL);
    assign accept = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: any seed load (re)starts replay; nothing leaves RUN but reset
    always_comb begin
        state_nxt = state;
        if (seed_load) state_nxt = RUN;
    end

    // Outputs: accept only when running, enabled, not reloading, and the
    // output slot is free or draining this cycle
    always_comb begin
        in_ready = 1'b0;
        if (state == RUN)
            in_ready = ena & ~seed_load & (~out_valid | out_ready);
    end

    // Output register: seed load discards, accept replaces, drain clears valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (seed_load) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= '{grad: grad_in & mask, mask: mask};
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accepted-beat counter, cleared on seed load, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt <= '0;
        else if (seed_load)
            beat_cnt <= '0;
        else if (accept && beat_cnt != 16'hFFFF)
            beat_cnt <= beat_cnt + 16'd1;
    end

    assign grad_out = out_q.grad;
    assign mask_out = out_q.mask;

endmodule

// File: tb/tb_dropout_mask_replay.sv
// Directed bench for dropout_mask_replay. Inputs change and outputs are
// sampled on the falling edge; a DROP_LVL=0 instance shares the stimulus.
module tb_dropout_mask_replay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0, seed_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] seed = '0;
    logic [7:0]  grad_in = '0;
    logic        in_ready, out_valid;
    logic [7:0]  grad_out, mask_out;
    logic [15:0] beat_cnt;
    logic        in_ready0, out_valid0;
    logic [7:0]  grad_out0, mask_out0;
    logic [15:0] beat_cnt0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dropout_mask_replay #(.DROP_LVL(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .grad_in(grad_in),
        .out_valid(out_valid), .out_ready(out_ready), .grad_out(grad_out),
        .mask_out(mask_out), .beat_cnt(beat_cnt)
    );

    dropout_mask_replay #(.DROP_LVL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready0), .grad_in(grad_in),
        .out_valid(out_valid0), .out_ready(out_ready), .grad_out(grad_out0),
        .mask_out(mask_out0), .beat_cnt(beat_cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference LFSR step and mask, written out bit by bit
    function automatic logic [15:0] m_next(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    function automatic logic [7:0] m_mask(input logic [15:0] l, input int lvl);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (int'({l[2*i+1], l[2*i]}) >= lvl);
        return m;
    endfunction

    logic [15:0] m;
    int          cnt;
    int          n0;
    logic        iv;
    logic [7:0]  g;
    logic [7:0]  hold_m;

    initial begin
        // ---- reset values
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_grad",  grad_out, 0);
        chk("rst_mask",  mask_out, 0);
        chk("rst_cnt",   beat_cnt, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1; in_valid = 1'b1; grad_in = 8'hFF; out_ready = 1'b1;
        #1 chk("idle_ready", in_ready, 0);

        // ---- T1: seed 0x0001, DROP_LVL=2
        @(negedge clk);
        seed = 16'h0001; seed_load = 1'b1;
        #1 chk("load_ready", in_ready, 0);
        tick();
        seed_load = 1'b0;
        #1 chk("run_ready", in_ready, 1);
        tick();
        chk("t1_b0_valid", out_valid, 1);
        chk("t1_b0_mask", mask_out, 8'h00);
        chk("t1_b0_grad", grad_out, 8'h00);
        tick();
        chk("t1_b1_mask", mask_out, 8'h01);
        chk("t1_b1_grad", grad_out, 8'h01);
        chk("t1_cnt", beat_cnt, 2);
        in_valid = 1'b0;
        tick();
        chk("t1_drain", out_valid, 0);

        // ---- T2: zero seed -> 0xACE1
        seed = 16'h0000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; in_valid = 1'b1; grad_in = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk("t2_mask", mask_out, 8'hEC);
        chk("t2_grad", grad_out, 8'hEC);
        chk("t2_cnt", beat_cnt, 1);
        tick();

        // ---- T4: backpressure
        seed = 16'h0000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; in_valid = 1'b1; grad_in = 8'hFF; out_ready = 1'b0;
        tick();
        chk("bp_valid", out_valid, 1);
        #1 chk("bp_ready0", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_mask", mask_out, 8'hEC);
            chk("bp_hold_grad", grad_out, 8'hEC);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_cnt", beat_cnt, 1);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_b1_mask", mask_out, 8'h29);
        chk("bp_b1_grad", grad_out, 8'h29);
        chk("bp_b1_cnt", beat_cnt, 2);

        // ---- T5: seed_load over a held beat, then long stream vs model
        out_ready = 1'b0;
        tick();
        chk("t5_held", out_valid, 1);
        seed = 16'h1234; seed_load = 1'b1;
        tick();
        chk("t5_discard", out_valid, 0);
        chk("t5_cnt0", beat_cnt, 0);
        seed_load = 1'b0; out_ready = 1'b1;
        m = 16'h1234; cnt = 0; n0 = 0;
        for (int i = 0; i < 1000; i++) begin
            iv = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            g  = 8'($urandom);
            in_valid = iv; grad_in = g;
            tick();
            chk("s_valid", out_valid, 32'(iv));
            if (iv) begin
                chk("s_mask", mask_out, m_mask(m, 2));
                chk("s_grad", grad_out, g & m_mask(m, 2));
                m = m_next(m);
                cnt++;
                if (n0 < 100) begin
                    chk("l0_mask", mask_out0, 8'hFF);
                    chk("l0_grad", grad_out0, g);
                    n0++;
                end
            end
            chk("s_cnt", beat_cnt, cnt);
        end

        // ---- T6: ena low freezes intake; pending beat still drains
        in_valid = 1'b1; grad_in = 8'hFF; ena = 1'b0;
        #1 chk("ena_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ena_cnt", beat_cnt, cnt);
            chk("ena_ready_hold", in_ready, 0);
        end
        chk("ena_drained", out_valid, 0);
        ena = 1'b1;
        tick();
        chk("ena_resume_mask", mask_out, m_mask(m, 2));
        chk("ena_resume_cnt", beat_cnt, cnt + 1);
        hold_m = mask_out;

        // async reset in the middle of a beat
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_grad", grad_out, 0);
        chk("ar_mask", mask_out, 0);
        chk("ar_cnt", beat_cnt, 0);
        chk("ar_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_idle_ready", in_ready, 0);
        chk("ar_idle_valid", out_valid, 0);
        seed = 16'h0001; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        chk("ar_reseed_mask", mask_out, 8'h00);
        chk("ar_reseed_cnt", beat_cnt, 1);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
